// File: rtl/video_pkg.sv
// Shared video types and constants for the pixel streaming blocks.
package video_pkg;

    // Nominal active line length; instantiators use it as the default FIFO depth.
    localparam int LINE_WIDTH = 800;

    // One RGB888 pixel.
    typedef logic [23:0] pixel_t;

    localparam int PIXEL_BITS = $bits(pixel_t);

endpackage

// File: rtl/line_stream_fifo_if.sv
// Ingress/egress valid-ready stream bundle for line_stream_fifo.
// The master is the surroundings (upstream producer and downstream consumer).
// The slave is the FIFO.
interface line_stream_fifo_if
    import video_pkg::*;
#(
    parameter int DATA_WIDTH = PIXEL_BITS
);

    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o
    );

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o
    );

endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one write port and one read port.
// The read data is registered, so read data appears one cycle after read_enable_i.
// The read register holds its value while no read is issued.
module dual_port_ram #(
    parameter  int DATA_WIDTH = 24,
    parameter  int ITEM_COUNT = 800,
    localparam int AddrBits   = (ITEM_COUNT > 1) ? $clog2(ITEM_COUNT) : 1
) (
    input  logic                  clock_i,
    input  logic                  write_enable_i,
    input  logic [AddrBits-1:0]   write_address_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic                  read_enable_i,
    input  logic [AddrBits-1:0]   read_address_i,
    output logic [DATA_WIDTH-1:0] read_data_o
);

    logic [DATA_WIDTH-1:0] r_mem [ITEM_COUNT];
    logic [DATA_WIDTH-1:0] r_read_data;

    // Write port: store the incoming word at the write address.
    // NOTE: the storage array has no reset, so it maps onto block RAM.
    //       Sequential state is always assigned with <= so that every register samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (write_enable_i) begin
            r_mem[write_address_i] <= write_data_i;
        end
    end

    // Read port: capture the addressed word; hold it while no read is issued.
    always_ff @(posedge clock_i) begin
        if (read_enable_i) begin
            r_read_data <= r_mem[read_address_i];
        end
    end

    assign read_data_o = r_read_data;

endmodule

// File: rtl/line_stream_fifo.sv
// Streaming FIFO that sits on the read side of a dual_port_ram.
// The RAM read register doubles as the output stage.
// Capacity is DEPTH words in RAM plus one word in the output register.
// in_ready_o depends only on registered occupancy, so there is no path from out_ready_i to in_ready_o.
module line_stream_fifo
    import video_pkg::*;
#(
    parameter  int DATA_WIDTH = PIXEL_BITS,
    parameter  int DEPTH      = LINE_WIDTH,
    localparam int CountBits  = $clog2(DEPTH + 2)
) (
    input  logic                 clock_i,
    input  logic                 reset_ni,
    input  logic                 flush_i,
    line_stream_fifo_if.slave    stream,
    output logic [CountBits-1:0] count_o
);

    localparam int                   PtrBits   = $clog2(DEPTH);
    localparam logic [PtrBits-1:0]   PtrLast   = PtrBits'(DEPTH - 1);
    localparam logic [CountBits-1:0] CountFull = CountBits'(DEPTH);

    logic [PtrBits-1:0]   r_wr_ptr;
    logic [PtrBits-1:0]   r_rd_ptr;
    logic [CountBits-1:0] r_ram_count;
    logic                 r_out_valid;

    logic                 w_in_ready;
    logic                 w_push;
    logic                 w_rd_en;

    // Accept while RAM has room.
    // A read in the same cycle only frees space for the next cycle.
    assign w_in_ready = (r_ram_count < CountFull);
    assign w_push     = stream.in_valid_i & w_in_ready;

    // Refill the output register when it is empty or is being consumed this cycle.
    assign w_rd_en = (r_ram_count != '0) & (~r_out_valid | stream.out_ready_i);

    // Write and read pointers wrap with an explicit compare.
    // DEPTH need not be a power of two.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    // RAM occupancy: a push adds one, a read removes one, and both together cancel.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_ram_count <= '0;
        end else if (flush_i) begin
            r_ram_count <= '0;
        end else begin
            case ({w_push, w_rd_en})
                2'b10:   r_ram_count <= r_ram_count + 1'b1;
                2'b01:   r_ram_count <= r_ram_count - 1'b1;
                default: r_ram_count <= r_ram_count;
            endcase
        end
    end

    // Output stage valid: set by a read, held while the consumer stalls.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_out_valid <= 1'b0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_rd_en | (r_out_valid & ~stream.out_ready_i);
        end
    end

    dual_port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ITEM_COUNT (DEPTH)
    ) u_ram (
        .clock_i         (clock_i),
        .write_enable_i  (w_push),
        .write_address_i (r_wr_ptr),
        .write_data_i    (stream.in_data_i),
        .read_enable_i   (w_rd_en),
        .read_address_i  (r_rd_ptr),
        .read_data_o     (stream.out_data_o)
    );

    assign stream.in_ready_o  = w_in_ready;
    assign stream.out_valid_o = r_out_valid;
    assign count_o            = r_ram_count + CountBits'(r_out_valid);

endmodule

// File: tb/tb_line_stream_fifo.sv
// Directed bench for line_stream_fifo at DEPTH=4.
// A scoreboard queue records accepted words, and pops are compared against it.
module tb_line_stream_fifo;
    import video_pkg::*;

    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int CB    = $clog2(DEPTH + 2);

    logic          clock_i  = 1'b0;
    logic          reset_ni = 1'b0;
    logic          flush_i  = 1'b0;
    logic [CB-1:0] count_o;

    line_stream_fifo_if #(.DATA_WIDTH(DW)) bus ();

    line_stream_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .flush_i  (flush_i),
        .stream   (bus),
        .count_o  (count_o)
    );

    always #5 clock_i = ~clock_i;

    int              tests      = 0;
    int              fails      = 0;
    int              pop_count  = 0;
    logic            last_push  = 1'b0;
    logic            prev_stall = 1'b0;
    logic [DW-1:0]   prev_data  = '0;
    logic [DW-1:0]   q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample the handshakes before the edge, advance one clock, then update the scoreboard.
    task automatic tick();
        logic          push_s, pop_s, flush_s, rst_s, stall_s;
        logic [DW-1:0] idata, odata;
        push_s  = bus.in_valid_i & bus.in_ready_o;
        pop_s   = bus.out_valid_o & bus.out_ready_i;
        stall_s = bus.out_valid_o & ~bus.out_ready_i;
        flush_s = flush_i;
        rst_s   = reset_ni;
        idata   = bus.in_data_i;
        odata   = bus.out_data_o;
        if (prev_stall) begin
            check("stall_valid", bus.out_valid_o, 1);
            check("stall_data", odata, prev_data);
        end
        last_push = 1'b0;
        @(posedge clock_i);
        #1;
        if (!rst_s || !reset_ni || flush_s) begin
            q.delete();
        end else begin
            if (pop_s) begin
                if (q.size() == 0) check("sb_unexpected", odata, 32'hDEADBEEF);
                else check("sb_data", odata, q.pop_front());
                pop_count++;
            end
            if (push_s) q.push_back(idata);
            last_push = push_s;
        end
        check("count", count_o, q.size());
        prev_stall = stall_s & rst_s & ~flush_s;
        prev_data  = odata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int guard;
        int k;
        int i;
        int pat[4];
        pat = '{1, 0, 0, 1};
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;

        // Reset values
        repeat (3) @(posedge clock_i);
        #1;
        check("rst_in_ready", bus.in_ready_o, 1);
        check("rst_out_valid", bus.out_valid_o, 0);
        check("rst_count", count_o, 0);
        reset_ni = 1'b1;
        tick();

        // Empty latency
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 24'hA1;
        tick();
        bus.in_valid_i = 1'b0;
        check("lat_c1_count", count_o, 1);
        check("lat_c1_valid", bus.out_valid_o, 0);
        tick();
        check("lat_c2_valid", bus.out_valid_o, 1);
        check("lat_c2_data", bus.out_data_o, 24'hA1);
        tick();
        check("lat_c3_count", count_o, 0);

        // Fill to full with the consumer stalled
        bus.out_ready_i = 1'b0;
        p0 = pop_count;
        for (int d = 1; d <= 5; d++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = DW'(d);
            tick();
            check("fill_accept", last_push, 1);
        end
        check("full_in_ready", bus.in_ready_o, 0);
        check("full_count", count_o, 5);
        bus.in_data_i = 24'h06;
        repeat (3) begin
            tick();
            check("full_hold", last_push, 0);
        end
        check("full_head", bus.out_data_o, 24'h01);
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        tick();
        check("full_release_ready", bus.in_ready_o, 1);
        guard = 0;
        while (count_o != 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("drain_bound", guard < 20, 1);
        check("fill_pops", pop_count - p0, 5);

        // Streaming: one word per cycle, several pointer wraps
        p0 = pop_count;
        for (int d = 0; d < 20; d++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = DW'(d);
            tick();
            check("stream_accept", last_push, 1);
        end
        bus.in_valid_i = 1'b0;
        tick();
        tick();
        check("stream_pops", pop_count - p0, 20);
        check("stream_idle_valid", bus.out_valid_o, 0);

        // Backpressure: the ready pattern 1,0,0,1 repeats
        p0 = pop_count;
        guard = 0;
        k = 0;
        i = 0;
        while (i < 8 && guard < 60) begin
            bus.in_valid_i  = 1'b1;
            bus.in_data_i   = DW'(32'h40 + i);
            bus.out_ready_i = pat[k % 4][0];
            k++;
            tick();
            if (last_push) i++;
            guard++;
        end
        check("bp_push_bound", guard < 60, 1);
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        guard = 0;
        while (count_o != 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("bp_drain_bound", guard < 20, 1);
        check("bp_pops", pop_count - p0, 8);

        // Flush with a concurrent push and pop
        bus.out_ready_i = 1'b0;
        for (int d = 0; d < 3; d++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = DW'(32'h31 + d);
            tick();
        end
        bus.in_valid_i = 1'b0;
        check("pre_flush_count", count_o, 3);
        flush_i         = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 24'h55;
        bus.out_ready_i = 1'b1;
        tick();
        flush_i        = 1'b0;
        bus.in_valid_i = 1'b0;
        check("flush_count", count_o, 0);
        check("flush_valid", bus.out_valid_o, 0);
        repeat (4) begin
            tick();
            check("post_flush_valid", bus.out_valid_o, 0);
        end

        // Asynchronous reset mid-stream
        bus.out_ready_i = 1'b0;
        for (int d = 0; d < 3; d++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = DW'(32'h61 + d);
            tick();
        end
        bus.in_valid_i = 1'b0;
        check("pre_reset_count", count_o, 3);
        #2;
        reset_ni   = 1'b0;
        prev_stall = 1'b0;
        #1;
        check("mid_rst_in_ready", bus.in_ready_o, 1);
        check("mid_rst_valid", bus.out_valid_o, 0);
        check("mid_rst_count", count_o, 0);
        q.delete();
        tick();
        reset_ni = 1'b1;
        tick();
        check("post_rst_valid", bus.out_valid_o, 0);
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 24'h77;
        tick();
        bus.in_valid_i = 1'b0;
        check("post_rst_c1_valid", bus.out_valid_o, 0);
        tick();
        check("post_rst_c2_valid", bus.out_valid_o, 1);
        check("post_rst_c2_data", bus.out_data_o, 24'h77);
        tick();
        check("post_rst_empty", count_o, 0);

        check("sb_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
